// File: rtl/synth_bus_pkg.sv
// Shared definitions for the synthesizer register bus: default address map,
// per-voice register offsets as functions of the field byte count, and wave types.
package synth_bus_pkg;

    localparam logic [15:0] DEFAULT_BASE   = 16'h0010;
    localparam logic [15:0] DEFAULT_STRIDE = 16'h0020;

    localparam logic [1:0] WAVE_SAW      = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_NOISE    = 2'd3;

    localparam int NUM_MB_FIELDS = 6;

    typedef enum logic [2:0] {
        MB_INCR, MB_PULSE_WIDTH, MB_ATTACK, MB_DECAY, MB_SUSTAIN, MB_RELEASE
    } mb_field_e;

    typedef enum logic [2:0] {
        FLD_NONE, FLD_GATE, FLD_WAVE, FLD_LINEAR, FLD_MULTI
    } field_kind_e;

    typedef struct packed {
        field_kind_e kind;
        logic [2:0]  mb;
        logic [7:0]  byte_idx;
    } field_sel_t;

    function automatic int off_gate();
        return 0;
    endfunction

    function automatic int off_wave(input int b);
        return b + 1;
    endfunction

    function automatic int off_linear(input int b);
        return 6 * b + 2;
    endfunction

    function automatic int window_size(input int b);
        return 6 * b + 3;
    endfunction

    // Incr sits before WaveType; the other five multi-byte fields follow it back to back.
    function automatic int mb_offset(input int k, input int b);
        return (k == 0) ? 1 : k * b + 2;
    endfunction

    function automatic field_sel_t decode_offset(input int off, input int b);
        field_sel_t sel;
        sel = '{kind: FLD_NONE, mb: 3'd0, byte_idx: 8'd0};
        if (off == off_gate()) begin
            sel.kind = FLD_GATE;
        end else if (off == off_wave(b)) begin
            sel.kind = FLD_WAVE;
        end else if (off == off_linear(b)) begin
            sel.kind = FLD_LINEAR;
        end else begin
            for (int k = 0; k < NUM_MB_FIELDS; k++) begin
                if (off >= mb_offset(k, b) && off < mb_offset(k, b) + b) begin
                    sel.kind     = FLD_MULTI;
                    sel.mb       = 3'(k);
                    sel.byte_idx = 8'(off - mb_offset(k, b));
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// Two-stage capture of the asynchronous CPU bus into the Clock domain, with a
// single-cycle access strobe on each rising edge of the synchronised bus strobe.
module bus_sync (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_clock,
    input  logic [15:0] i_bus_address,
    input  logic [7:0]  i_bus_data,
    input  logic        i_bus_rw,
    output logic        o_strobe,
    output logic        o_bus_high,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    output logic        o_write
);

    logic        r_s1_clk, r_s2_clk, r_s2_prev;
    logic        r_s1_valid, r_s2_valid, r_armed;
    logic [15:0] r_s1_addr, r_s2_addr;
    logic [7:0]  r_s1_data, r_s2_data;
    logic        r_s1_rw, r_s2_rw;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1_clk   <= 1'b0;
            r_s2_clk   <= 1'b0;
            r_s2_prev  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_armed    <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_addr  <= '0;
            r_s1_data  <= '0;
            r_s2_data  <= '0;
            r_s1_rw    <= 1'b0;
            r_s2_rw    <= 1'b0;
        end else begin
            r_s1_clk   <= i_bus_clock;
            r_s1_addr  <= i_bus_address;
            r_s1_data  <= i_bus_data;
            r_s1_rw    <= i_bus_rw;
            r_s2_clk   <= r_s1_clk;
            r_s2_addr  <= r_s1_addr;
            r_s2_data  <= r_s1_data;
            r_s2_rw    <= r_s1_rw;
            r_s2_prev  <= r_s2_clk;
            r_s1_valid <= 1'b1;
            r_s2_valid <= r_s1_valid;
            // A strobe already high when reset lifts must be seen low once before it counts.
            if (r_s2_valid && !r_s2_clk) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_strobe   = r_armed & r_s2_clk & ~r_s2_prev;
    assign o_bus_high = r_armed & r_s2_clk;
    assign o_address  = r_s2_addr;
    assign o_data     = r_s2_data;
    assign o_write    = r_s2_rw;

endmodule

// File: rtl/voice_register_bank.sv
// Memory-mapped per-voice parameter registers with shadowed atomic multi-byte
// fields, gate edge pulses and a registered tri-state read-back path.
module voice_register_bank
    import synth_bus_pkg::*;
#(
    parameter int          NUM_VOICES = 4,
    parameter int          W          = 24,
    parameter logic [15:0] BASE       = DEFAULT_BASE,
    parameter logic [15:0] STRIDE     = DEFAULT_STRIDE
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [15:0]             BusAddress,
    inout  wire  [7:0]              BusData,
    input  logic                    BusReadWrite,
    input  logic                    BusClock,
    output logic [NUM_VOICES-1:0]   Gate,
    output logic [NUM_VOICES-1:0]   NoteOn,
    output logic [NUM_VOICES-1:0]   NoteOff,
    output logic [NUM_VOICES*W-1:0] Incr,
    output logic [NUM_VOICES*W-1:0] PulseWidth,
    output logic [NUM_VOICES*W-1:0] Attack,
    output logic [NUM_VOICES*W-1:0] Decay,
    output logic [NUM_VOICES*W-1:0] Sustain,
    output logic [NUM_VOICES*W-1:0] Release,
    output logic [NUM_VOICES*2-1:0] WaveType,
    output logic [NUM_VOICES-1:0]   Linear
);

    localparam int         B        = W / 8;
    localparam int         WIN      = window_size(B);
    localparam int         VW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [7:0] TOP_BYTE = 8'(B - 1);

    function automatic int voice_base(input int v);
        return int'(BASE) + v * int'(STRIDE);
    endfunction

    logic          w_strobe, w_bus_high, w_write, w_hit, w_mapped;
    logic [15:0]   w_addr;
    logic [7:0]    w_data, w_rd_byte;
    logic [VW-1:0] w_voice;
    int            w_offset;
    field_sel_t    w_sel;
    logic [W-1:0]  w_commit;

    logic [NUM_VOICES-1:0] r_gate, r_note_on, r_note_off, r_linear;
    logic [1:0]            r_wave   [NUM_VOICES];
    logic [W-1:0]          r_live   [NUM_VOICES][NUM_MB_FIELDS];
    logic [W-1:0]          r_shadow [NUM_VOICES][NUM_MB_FIELDS];
    logic                  r_rd_en;
    logic [7:0]            r_rd_data;

    bus_sync u_bus_sync (
        .i_clock       (Clock),
        .i_reset       (Reset),
        .i_bus_clock   (BusClock),
        .i_bus_address (BusAddress),
        .i_bus_data    (BusData),
        .i_bus_rw      (BusReadWrite),
        .o_strobe      (w_strobe),
        .o_bus_high    (w_bus_high),
        .o_address     (w_addr),
        .o_data        (w_data),
        .o_write       (w_write)
    );

    // NOTE: every signal in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_hit    = 1'b0;
        w_voice  = '0;
        w_offset = 0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (int'(w_addr) >= voice_base(v) && int'(w_addr) < voice_base(v) + WIN) begin
                w_hit    = 1'b1;
                w_voice  = VW'(v);
                w_offset = int'(w_addr) - voice_base(v);
            end
        end
    end

    assign w_sel    = decode_offset(w_offset, B);
    assign w_mapped = w_hit && (w_sel.kind != FLD_NONE);

    // The top byte arrives on the bus; the lower bytes come from the shadow.
    always_comb begin
        w_commit            = r_shadow[w_voice][w_sel.mb];
        w_commit[W-1 -: 8]  = w_data;
    end

    always_comb begin
        w_rd_byte = '0;
        case (w_sel.kind)
            FLD_GATE:   w_rd_byte = {7'b0, r_gate[w_voice]};
            FLD_WAVE:   w_rd_byte = {6'b0, r_wave[w_voice]};
            FLD_LINEAR: w_rd_byte = {7'b0, r_linear[w_voice]};
            FLD_MULTI:  w_rd_byte = r_live[w_voice][w_sel.mb][w_sel.byte_idx*8 +: 8];
            default:    w_rd_byte = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_gate     <= '0;
            r_note_on  <= '0;
            r_note_off <= '0;
            r_linear   <= '0;
            r_rd_en    <= 1'b0;
            r_rd_data  <= '0;
            // NOTE: the whole register file is reset, so a partial multi-byte write never survives reset.
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_wave[v] <= '0;
                for (int k = 0; k < NUM_MB_FIELDS; k++) begin
                    r_live[v][k]   <= '0;
                    r_shadow[v][k] <= '0;
                end
            end
        end else begin
            r_note_on  <= '0;
            r_note_off <= '0;
            r_rd_en    <= w_bus_high & ~w_write & w_mapped;
            r_rd_data  <= w_rd_byte;
            if (w_strobe && w_write && w_mapped) begin
                case (w_sel.kind)
                    FLD_GATE: begin
                        r_gate[w_voice] <= w_data[0];
                        if ((!r_gate[w_voice] && w_data[0]) || (w_data[1] && w_data[0])) begin
                            r_note_on[w_voice] <= 1'b1;
                        end
                        if (r_gate[w_voice] && !w_data[0]) begin
                            r_note_off[w_voice] <= 1'b1;
                        end
                    end
                    FLD_WAVE:   r_wave[w_voice]   <= w_data[1:0];
                    FLD_LINEAR: r_linear[w_voice] <= w_data[0];
                    FLD_MULTI: begin
                        r_shadow[w_voice][w_sel.mb][w_sel.byte_idx*8 +: 8] <= w_data;
                        if (w_sel.byte_idx == TOP_BYTE) begin
                            r_live[w_voice][w_sel.mb] <= w_commit;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign BusData = r_rd_en ? r_rd_data : 8'bz;

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            Incr[v*W +: W]       = r_live[v][MB_INCR];
            PulseWidth[v*W +: W] = r_live[v][MB_PULSE_WIDTH];
            Attack[v*W +: W]     = r_live[v][MB_ATTACK];
            Decay[v*W +: W]      = r_live[v][MB_DECAY];
            Sustain[v*W +: W]    = r_live[v][MB_SUSTAIN];
            Release[v*W +: W]    = r_live[v][MB_RELEASE];
            WaveType[v*2 +: 2]   = r_wave[v];
        end
    end

    assign Gate    = r_gate;
    assign NoteOn  = r_note_on;
    assign NoteOff = r_note_off;
    assign Linear  = r_linear;

endmodule
